// File: rtl/btn_debounce.sv
// btn_debounce: per-channel synchronizer, debouncer, press/release pulses and long-press detector
module btn_debounce #(
    parameter int          N        = 4,
    parameter logic [31:0] DEBOUNCE = 32'd120000,
    parameter logic [31:0] LONG     = 32'd12000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] state,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] long
);
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic        sync1, sync2, st, pr, rl, lg, fired, accept;
        logic [31:0] cnt, hold;
        assign accept   = (sync2 != st) && (cnt == DEBOUNCE - 32'd1);
        assign state[i] = st;
        assign press[i] = pr;
        assign rel[i]   = rl;
        assign long[i]  = lg;
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                st    <= 1'b0;
                pr    <= 1'b0;
                rl    <= 1'b0;
                lg    <= 1'b0;
                fired <= 1'b0;
                cnt   <= '0;
                hold  <= '0;
            end else begin
                sync1 <= btn[i];
                sync2 <= sync1;
                cnt   <= (sync2 == st || accept) ? '0 : cnt + 32'd1;
                if (accept) st <= sync2;
                pr <= accept & sync2;
                rl <= accept & ~sync2;
                // an accepted release on this edge (accept while st is high) suppresses long
                lg <= st & ~fired & (hold == LONG - 32'd1) & ~accept;
                if (accept & sync2) begin
                    hold  <= '0;
                    fired <= 1'b0;
                end else if (st & ~fired) begin
                    if (hold == LONG - 32'd1) fired <= 1'b1;
                    else hold <= hold + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed plus randomized stimulus against an edge-history reference model
module tb_btn_debounce;
    localparam int N = 4;
    localparam int D = 4;
    localparam int L = 10;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] state, press, rel, long;
    int checks = 0;
    int errors = 0;

    btn_debounce #(.N(N), .DEBOUNCE(32'(D)), .LONG(32'(L))) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .state(state), .press(press), .rel(rel), .long(long)
    );

    always #5 clk = ~clk;

    // reference: btn history per edge, acceptance = D consecutive synchronized samples differing from level
    logic [N-1:0] bh [0:16383];
    logic [N-1:0] sh [0:16383];
    logic [N-1:0] m_st = '0, m_pr = '0, m_rl = '0, m_lg = '0;
    int age [N];
    int k = 0;
    int r_edge = -100;

    always @(posedge clk) begin
        logic [N-1:0] s2;
        logic acc;
        bh[k] = btn;
        if (rst) begin
            r_edge = k;
            m_st = '0; m_pr = '0; m_rl = '0; m_lg = '0;
            for (int i = 0; i < N; i++) age[i] = -1;
        end else begin
            s2 = (k - 2 > r_edge) ? bh[k-2] : '0;
            sh[k] = s2;
            for (int i = 0; i < N; i++) begin
                acc = (k - D + 1 > r_edge);
                if (acc)
                    for (int j = k - D + 1; j <= k; j++)
                        if (sh[j][i] == m_st[i]) acc = 1'b0;
                m_pr[i] = acc & ~m_st[i];
                m_rl[i] = acc & m_st[i];
                if (acc) m_st[i] = ~m_st[i];
                if (m_pr[i]) age[i] = 0;
                else if (!m_st[i]) age[i] = -1;
                else if (age[i] >= 0) age[i]++;
                m_lg[i] = (age[i] == L);
            end
        end
        k++;
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", tag, k, got, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] b, input logic r, input int n);
        repeat (n) begin
            @(negedge clk);
            check("state", state, m_st);
            check("press", press, m_pr);
            check("release", rel, m_rl);
            check("long", long, m_lg);
            if ((press & rel) != '0) check("press_and_release", press & rel, '0);
            btn = b;
            rst = r;
        end
    endtask

    initial begin
        int run [N];
        logic [N-1:0] b;
        step(4'b0000, 1'b1, 2);
        step(4'b0000, 1'b0, 3);
        step(4'b0001, 1'b0, 12);
        step(4'b0000, 1'b0, 8);
        step(4'b0010, 1'b0, 3);
        step(4'b0000, 1'b0, 1);
        step(4'b0010, 1'b0, 3);
        step(4'b0000, 1'b0, 3);
        step(4'b0010, 1'b0, 6);
        step(4'b0000, 1'b0, 8);
        step(4'b0100, 1'b0, 20);
        step(4'b0000, 1'b0, 15);
        step(4'b1000, 1'b0, 7);
        step(4'b0000, 1'b0, 8);
        step(4'b1000, 1'b0, 15);
        step(4'b0000, 1'b0, 10);
        step(4'b0100, 1'b0, 12);
        step(4'b0101, 1'b0, 4);
        step(4'b0101, 1'b1, 1);
        step(4'b0101, 1'b0, 25);
        step(4'b0000, 1'b0, 10);
        step(4'b1111, 1'b0, 25);
        step(4'b0000, 1'b0, 10);
        b = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (run[i] == 0) begin
                    b[i] = ~b[i];
                    run[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 25);
                end else run[i]--;
            end
            step(b, $urandom_range(0, 299) == 0, 1);
        end
        step(4'b0000, 1'b0, 12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
